// File: rtl/sort_nb_reader_if.sv
// Result bus between the 8-entry byte sorter, the serial reader and the
// downstream byte consumer. The reader uses the master modport and the
// environment around it uses the slave modport.
interface sort_nb_reader_if;
  logic       i_complete;
  logic [7:0] i_d [0:7];
  logic [7:0] o_dout;
  logic       o_doutValid;
  logic       i_doutReady;
  logic       o_doutLast;
  logic       o_busy;
  logic       o_done;
  logic       o_sortedErr;
  logic [2:0] o_idx;

  modport master (
    input  i_complete,
    input  i_d,
    input  i_doutReady,
    output o_dout,
    output o_doutValid,
    output o_doutLast,
    output o_busy,
    output o_done,
    output o_sortedErr,
    output o_idx
  );

  modport slave (
    output i_complete,
    output i_d,
    output i_doutReady,
    input  o_dout,
    input  o_doutValid,
    input  o_doutLast,
    input  o_busy,
    input  o_done,
    input  o_sortedErr,
    input  o_idx
  );
endinterface

// File: rtl/sort_nb_reader.sv
// Consumer end of the 8-entry byte sorter. Waits for the sorter's complete
// level, snapshots D0..D7 in one cycle, then streams the snapshot out on a
// valid/ready handshake (D0 first) while checking that the stream is
// monotonic. An ordering violation raises a flag that stays set until the
// next capture or reset.
module sort_nb_reader #(
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  sort_nb_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [7:0] r_buf [0:7];
  logic [7:0] r_prev;
  logic [7:0] r_dout;
  logic       r_doutValid;
  logic       r_doutLast;
  logic       r_sortedErr;
  logic [2:0] r_idx;

  logic       w_transfer;
  logic       w_lastTransfer;
  logic       w_violation;
  logic [2:0] w_nextIdx;

  // Handshake decode and the on-the-fly order check; the first byte of a
  // stream has no predecessor, so it is never compared against stale prev.
  always_comb begin
    w_transfer     = (r_state == SEND) && r_doutValid && bus.i_doutReady;
    w_lastTransfer = w_transfer && (r_idx == 3'd7);
    w_nextIdx      = r_idx + 3'd1;
    w_violation    = 1'b0;
    if (w_transfer && (r_idx != 3'd0)) begin
      if (DESCEND) begin
        w_violation = (r_dout > r_prev);
      end else begin
        w_violation = (r_dout < r_prev);
      end
    end
  end

  // Next-state logic: a held-high complete parks the block in DONE so the
  // same result is never streamed twice; complete must drop to re-arm.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.i_complete) w_nextState = CAPTURE;
      CAPTURE: w_nextState = SEND;
      SEND:    if (w_lastTransfer) w_nextState = DONE;
      DONE:    if (!bus.i_complete) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Snapshot of the sorter outputs, taken only in CAPTURE so later changes
  // on D0..D7 cannot leak into the stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        r_buf[k] <= 8'd0;
      end
    end else if (r_state == CAPTURE) begin
      for (int k = 0; k < 8; k++) begin
        r_buf[k] <= bus.i_d[k];
      end
    end
  end

  // Registered stream output. The first SEND cycle loads byte 0; after that
  // each transfer loads the following byte in the same edge so an always-ready
  // consumer gets eight back-to-back bytes. Without a transfer dout holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout      <= 8'd0;
      r_doutValid <= 1'b0;
      r_doutLast  <= 1'b0;
      r_sortedErr <= 1'b0;
      r_idx       <= 3'd0;
      r_prev      <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_doutValid <= 1'b0;
          r_doutLast  <= 1'b0;
          r_idx       <= 3'd0;
        end
        CAPTURE: begin
          r_doutValid <= 1'b0;
          r_doutLast  <= 1'b0;
          r_idx       <= 3'd0;
          r_sortedErr <= 1'b0;
        end
        SEND: begin
          if (!r_doutValid) begin
            r_dout      <= r_buf[r_idx];
            r_doutValid <= 1'b1;
            r_doutLast  <= (r_idx == 3'd7);
          end else if (w_transfer) begin
            r_prev <= r_dout;
            if (w_violation) begin
              r_sortedErr <= 1'b1;
            end
            if (r_idx == 3'd7) begin
              r_doutValid <= 1'b0;
              r_doutLast  <= 1'b0;
            end else begin
              r_idx      <= w_nextIdx;
              r_dout     <= r_buf[w_nextIdx];
              r_doutLast <= (w_nextIdx == 3'd7);
            end
          end
        end
        default: begin
          r_doutValid <= 1'b0;
          r_doutLast  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_dout      = r_dout;
  assign bus.o_doutValid = r_doutValid;
  assign bus.o_doutLast  = r_doutLast;
  assign bus.o_sortedErr = r_sortedErr;
  assign bus.o_idx       = r_idx;
  assign bus.o_busy      = (r_state == CAPTURE) || (r_state == SEND);
  assign bus.o_done      = (r_state == DONE);

endmodule

// File: tb/tb_sort_nb_reader.sv
// Directed bench for sort_nb_reader. Instance A checks non-decreasing order,
// instance B checks non-increasing order. Expected streams and error
// positions are hand-written constants.
module tb_sort_nb_reader;

  logic clk;
  logic reset;

  int nAsserts;
  int nFails;

  logic [7:0] expStream [0:7];

  sort_nb_reader_if busA ();
  sort_nb_reader_if busD ();

  sort_nb_reader #(.DESCEND(1'b0)) uAsc (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.master)
  );

  sort_nb_reader #(.DESCEND(1'b1)) uDesc (
    .clk   (clk),
    .reset (reset),
    .bus   (busD.master)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives complete and D0..D7 (D0 in the top byte) of one instance.
  task automatic applyStimulus(input bit sel, input logic comp, input logic [63:0] data);
    for (int k = 0; k < 8; k++) begin
      if (sel) busD.i_d[k] = data[63 - 8*k -: 8];
      else     busA.i_d[k] = data[63 - 8*k -: 8];
    end
    if (sel) busD.i_complete = comp;
    else     busA.i_complete = comp;
  endtask

  task automatic setExpected(input logic [63:0] data);
    for (int k = 0; k < 8; k++) expStream[k] = data[63 - 8*k -: 8];
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag, input bit sel);
    checkOutput({tag, "_valid"}, sel ? busD.o_doutValid : busA.o_doutValid, 0);
    checkOutput({tag, "_last"},  sel ? busD.o_doutLast  : busA.o_doutLast,  0);
    checkOutput({tag, "_busy"},  sel ? busD.o_busy      : busA.o_busy,      0);
    checkOutput({tag, "_done"},  sel ? busD.o_done      : busA.o_done,      0);
    checkOutput({tag, "_err"},   sel ? busD.o_sortedErr : busA.o_sortedErr, 0);
    checkOutput({tag, "_idx"},   sel ? busD.o_idx       : busA.o_idx,       0);
    checkOutput({tag, "_dout"},  sel ? busD.o_dout      : busA.o_dout,      0);
  endtask

  // Consumes a stream, called right after complete is raised from IDLE.
  // readyMode 0 = always ready, 1 = ready pattern 1,0,0,1,0,1 repeating.
  // errIdx = index of the first violating byte (8 = none). clobberAt = cycle
  // at which D0..D7 are overwritten with 0xFF (-1 = never).
  task automatic runStream(input string tag, input bit sel, input int readyMode,
                           input int maxXfers, input int errIdx, input int clobberAt);
    int got = 0;
    int cycles = 0;
    int firstValid = -1;
    int firstXfer = -1;
    int lastXfer = -1;
    bit pend = 1'b0;
    logic [7:0] held = 8'd0;
    logic rdy, v, lst, err;
    logic [7:0] dt;
    logic [2:0] ix;
    logic [5:0] pat;
    pat = 6'b101001;
    while (got < maxXfers && cycles < 200) begin
      rdy = (readyMode == 0) ? 1'b1 : pat[cycles % 6];
      if (sel) busD.i_doutReady = rdy;
      else     busA.i_doutReady = rdy;
      if (cycles == clobberAt) applyStimulus(sel, 1'b1, {8{8'hFF}});
      v   = sel ? busD.o_doutValid : busA.o_doutValid;
      dt  = sel ? busD.o_dout      : busA.o_dout;
      lst = sel ? busD.o_doutLast  : busA.o_doutLast;
      err = sel ? busD.o_sortedErr : busA.o_sortedErr;
      ix  = sel ? busD.o_idx       : busA.o_idx;
      if (v && firstValid < 0) firstValid = cycles;
      if (pend) begin
        checkOutput({tag, "_holdValid"}, v, 1);
        checkOutput({tag, "_holdDout"}, dt, held);
      end
      if (v && rdy) begin
        checkOutput($sformatf("%s_byte%0d", tag, got), dt, expStream[got]);
        checkOutput($sformatf("%s_last%0d", tag, got), lst, (got == 7));
        checkOutput($sformatf("%s_idx%0d", tag, got), ix, got);
        checkOutput($sformatf("%s_err%0d", tag, got), err, (got > errIdx));
        if (firstXfer < 0) firstXfer = cycles;
        lastXfer = cycles;
        got++;
        pend = 1'b0;
      end else if (v) begin
        pend = 1'b1;
        held = dt;
      end
      nextCycle();
      cycles++;
    end
    checkOutput({tag, "_count"}, got, maxXfers);
    checkOutput({tag, "_latency"}, firstValid, 3);
    if (readyMode == 0 && maxXfers == 8) begin
      checkOutput({tag, "_backToBack"}, lastXfer - firstXfer, 7);
    end
    if (maxXfers == 8) begin
      checkOutput({tag, "_doneFlag"}, sel ? busD.o_done : busA.o_done, 1);
      checkOutput({tag, "_doneValid"}, sel ? busD.o_doutValid : busA.o_doutValid, 0);
      checkOutput({tag, "_doneErr"}, sel ? busD.o_sortedErr : busA.o_sortedErr, (errIdx < 8));
      checkOutput({tag, "_doneBusy"}, sel ? busD.o_busy : busA.o_busy, 0);
    end
  endtask

  // Drops complete for one cycle so the instance returns to IDLE.
  task automatic rearm(input string tag, input bit sel, input logic [63:0] data);
    applyStimulus(sel, 1'b0, data);
    nextCycle();
    checkOutput({tag, "_rearmDone"}, sel ? busD.o_done : busA.o_done, 0);
    checkOutput({tag, "_rearmBusy"}, sel ? busD.o_busy : busA.o_busy, 0);
  endtask

  initial begin
    nAsserts = 0;
    nFails = 0;
    reset = 1'b1;
    busA.i_doutReady = 1'b1;
    busD.i_doutReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h04_05_01_03_02_06_08_07);
    applyStimulus(1'b1, 1'b0, 64'h04_05_01_03_02_06_08_07);
    setExpected(64'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkIdleOutputs("rstA", 1'b0);
    checkIdleOutputs("rstD", 1'b1);
    reset = 1'b0;
    nextCycle();
    checkIdleOutputs("idleA", 1'b0);

    // Sorted stream, always ready
    $display("[TB] sorted stream, ready high");
    applyStimulus(1'b0, 1'b1, 64'h01_02_03_04_05_06_07_08);
    setExpected(64'h01_02_03_04_05_06_07_08);
    runStream("sorted", 1'b0, 0, 8, 8, -1);

    // Order violation at byte 4 (4 after 9); the first byte is not compared
    // with the previous stream's last byte
    $display("[TB] order violation");
    rearm("viol", 1'b0, 64'h01_02_03_09_04_05_06_07);
    applyStimulus(1'b0, 1'b1, 64'h01_02_03_09_04_05_06_07);
    setExpected(64'h01_02_03_09_04_05_06_07);
    runStream("viol", 1'b0, 0, 8, 4, -1);

    // Backpressure with equal neighbours
    $display("[TB] backpressure");
    rearm("bp", 1'b0, 64'h03_03_07_09_0C_28_29_C8);
    applyStimulus(1'b0, 1'b1, 64'h03_03_07_09_0C_28_29_C8);
    setExpected(64'h03_03_07_09_0C_28_29_C8);
    runStream("bp", 1'b0, 1, 8, 8, -1);

    // Inputs overwritten after capture
    $display("[TB] inputs change after capture");
    rearm("snap", 1'b0, 64'h0A_14_1E_28_32_3C_46_50);
    applyStimulus(1'b0, 1'b1, 64'h0A_14_1E_28_32_3C_46_50);
    setExpected(64'h0A_14_1E_28_32_3C_46_50);
    runStream("snap", 1'b0, 0, 8, 8, 3);

    // Reset after the third transfer, then a fresh full stream
    $display("[TB] mid-stream reset");
    rearm("mid", 1'b0, 64'h01_02_03_04_05_06_07_08);
    applyStimulus(1'b0, 1'b1, 64'h01_02_03_04_05_06_07_08);
    setExpected(64'h01_02_03_04_05_06_07_08);
    runStream("mid", 1'b0, 0, 3, 8, -1);
    reset = 1'b1;
    nextCycle();
    checkIdleOutputs("midRst", 1'b0);
    reset = 1'b0;
    runStream("restart", 1'b0, 0, 8, 8, -1);

    // complete held high: no second stream
    $display("[TB] held complete");
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      checkOutput($sformatf("hold%0d_valid", c), busA.o_doutValid, 0);
      checkOutput($sformatf("hold%0d_done", c), busA.o_done, 1);
    end
    rearm("again", 1'b0, 64'h01_02_03_04_05_06_07_08);
    applyStimulus(1'b0, 1'b1, 64'h01_02_03_04_05_06_07_08);
    runStream("again", 1'b0, 0, 8, 8, -1);
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      checkOutput($sformatf("after%0d_valid", c), busA.o_doutValid, 0);
    end

    // Descending instance: clean 8..1, then ascending data flags byte 1
    $display("[TB] descending order");
    applyStimulus(1'b1, 1'b1, 64'h08_07_06_05_04_03_02_01);
    setExpected(64'h08_07_06_05_04_03_02_01);
    runStream("desc", 1'b1, 0, 8, 8, -1);
    rearm("descBad", 1'b1, 64'h01_02_03_04_05_06_07_08);
    applyStimulus(1'b1, 1'b1, 64'h01_02_03_04_05_06_07_08);
    setExpected(64'h01_02_03_04_05_06_07_08);
    runStream("descBad", 1'b1, 1, 8, 1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
